// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pins, validates 11-bit frames and
// queues scan codes in a small FIFO that the bus pops on the io_rdn rising edge.
module ps2_keyboard #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic [7:0] key_data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  // Frame layout after shifting: {stop, parity, data[7:0]}; valid needs stop=1 and odd ones.
  function automatic logic frame_ok(input logic [9:0] frame);
    return frame[9] & (^frame[8:0]);
  endfunction

  logic [2:0]            clk_sync_r;
  logic [1:0]            data_sync_r;
  logic                  fall_s;
  logic                  data_s;
  state_t                state_r, state_nxt_s;
  logic [3:0]            bitcnt_r, bitcnt_nxt_s;
  logic [9:0]            shift_r, shift_nxt_s, shift_in_s;
  logic [TW-1:0]         to_cnt_r, to_cnt_nxt_s;
  logic                  push_s, err_s;
  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_r, rptr_r;
  logic [DEPTH_LOG2:0]   cnt_r;
  logic                  rdn_r;
  logic                  pop_s, full_s, wr_en_s;

  assign fall_s     = clk_sync_r[2] & ~clk_sync_r[1];
  assign data_s     = data_sync_r[1];
  assign shift_in_s = {data_s, shift_r[9:1]};

  // Two-flop synchronizers plus one history flop on the PS/2 clock for edge detect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Receive FSM state, bit counter, shift register, timeout counter and error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r   <= IDLE;
      bitcnt_r  <= 4'd0;
      shift_r   <= 10'd0;
      to_cnt_r  <= '0;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bitcnt_r  <= bitcnt_nxt_s;
      shift_r   <= shift_nxt_s;
      to_cnt_r  <= to_cnt_nxt_s;
      frame_err <= err_s;
    end
  end

  // Next-state logic: start-bit detection, bit collection, frame check and timeout.
  always_comb begin
    state_nxt_s  = state_r;
    bitcnt_nxt_s = bitcnt_r;
    shift_nxt_s  = shift_r;
    to_cnt_nxt_s = to_cnt_r;
    push_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        to_cnt_nxt_s = '0;
        if (fall_s && !data_s) begin
          state_nxt_s  = RECV;
          bitcnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      RECV: begin
        if (fall_s) begin
          shift_nxt_s  = shift_in_s;
          to_cnt_nxt_s = '0;
          if (bitcnt_r == 4'd9) begin
            state_nxt_s  = IDLE;
            bitcnt_nxt_s = 4'd0;
            if (frame_ok(shift_in_s)) begin
              push_s = 1'b1;
            end else begin
              err_s  = 1'b1;
            end
          end else begin
            bitcnt_nxt_s = bitcnt_r + 4'd1;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_nxt_s  = IDLE;
          bitcnt_nxt_s = 4'd0;
          to_cnt_nxt_s = '0;
          err_s        = 1'b1;
        end else begin
          to_cnt_nxt_s = to_cnt_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        bitcnt_nxt_s = 4'd0;
        to_cnt_nxt_s = '0;
      end
    endcase
  end

  // Pop on the io_rdn rising edge; a push into a full FIFO only lands alongside a pop.
  assign pop_s   = ~rdn_r & io_rdn & (cnt_r != '0);
  assign full_s  = (cnt_r == CNT_FULL);
  assign wr_en_s = push_s & (~full_s | pop_s);

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wptr_r   <= '0;
      rptr_r   <= '0;
      cnt_r    <= '0;
      rdn_r    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      rdn_r <= io_rdn;
      if (wr_en_s) begin
        mem_r[wptr_r] <= shift_in_s[7:0];
        wptr_r        <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      if (pop_s) begin
        overflow <= 1'b0;
      end else if (push_s && full_s) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ready    = (cnt_r != '0);
  assign key_data = ready ? mem_r[rptr_r] : 8'h00;

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard responder that sits on the i/o space of `mio_bus`. It receives 11-bit PS/2 device-to-host frames on the keyboard pins, checks each frame and queues valid scan codes in an 8-entry FIFO. It presents `{ready, key_data}` to the bus and pops one entry per `io_rdn` read strobe.

## Interface
Parameters:
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 entries.
- `TIMEOUT`, 100000: clk cycles allowed between PS/2 falling edges inside a frame (1 ms at 100 MHz).

Ports:
- `clk`  in  1  system clock. The single clock; all state is on its rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  PS/2 clock pin, asynchronous to clk.
- `ps2_data`  in  1  PS/2 data pin, asynchronous to clk.
- `io_rdn`  in  1  read strobe from the bus, active-low.
- `key_data`  out  8  FIFO head byte, combinational from the FIFO head; 0x00 when the FIFO is empty.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Synchronizer**
  - `ps2_clk` and `ps2_data` each pass through 2 flops; a third flop on `ps2_clk` provides edge history.
  - `fall` = previous synced `ps2_clk` is 1 and current synced `ps2_clk` is 0.
- **Receive FSM**, states IDLE and RECV, with a 4-bit counter `bitcnt` and a 10-bit shift register.
  - IDLE: on `fall` with data=0 (start bit), go to RECV with bitcnt=0. On `fall` with data=1, stay in IDLE (no error).
  - RECV: each `fall` shifts data in and increments bitcnt. The bits arrive as 8 data bits LSB first, then odd parity, then stop.
  - After the 10th bit in RECV (stop), return to IDLE and evaluate the frame.
    - Valid frame: stop=1 and the 8 data bits plus parity together hold an odd number of ones. A valid frame is pushed.
    - Otherwise pulse `frame_err` and push nothing.
- **Timeout**
  - A counter clears on every `fall` and counts while in RECV.
  - On reaching `TIMEOUT`: return to IDLE, clear bitcnt, pulse `frame_err`.
- **FIFO**
  - Circular buffer with `DEPTH_LOG2`-bit read and write pointers and a `DEPTH_LOG2+1`-bit count.
  - Pointers wrap modulo depth.
- **Pop**
  - Pop occurs on the `io_rdn` rising edge: registered `io_rdn` was 0 and current `io_rdn` is 1.
  - `key_data` therefore stays stable for the whole low phase of the strobe, and a strobe held low for many cycles pops exactly once.
  - A pop while the FIFO is empty is ignored.
- **Push**
  - Push is evaluated after the same-cycle pop. Pop and push on a full FIFO both take effect, count stays at 8, and `overflow` does not set.
  - Push on a full FIFO with no pop drops the byte and sets `overflow`.
- **`overflow` clearing**: cleared on any pop that takes effect, or by reset.

## Timing
- **Reset**: `clrn`=0 asynchronously forces the following.
  - FSM to IDLE; bitcnt, pointers, count and timeout counter to 0.
  - Synchronizer flops to 1.
  - Outputs: `ready`=0, `key_data`=0x00, `overflow`=0, `frame_err`=0.
  - Reset mid-frame discards the partial frame. The next frame after release is received normally.
- **Edge latency**: `fall` is asserted 3 clk cycles after the `ps2_clk` pin falls.
- **Push latency**: the FIFO write and count increment happen on the clk edge after `fall` for the stop bit. `ready` and `key_data` are valid on the following cycle.
- **Pop latency**: the head advances on the clk edge after the cycle in which `io_rdn` is sampled high. `key_data` and `ready` update in the next cycle.
- **`frame_err`**: high for exactly 1 cycle, on the cycle of the stop-bit evaluation or of the timeout.
- **Minimum strobe**: `io_rdn` must be low for at least 1 clk cycle. A glitch shorter than a cycle is not guaranteed to pop.

## Test plan
- **Single byte**: send frame 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1), PS/2 clock at 10 kHz. Expect `ready`=1 and `key_data`=0x1C. Then pulse `io_rdn` low for 10 cycles; expect exactly one pop, `ready`=0 and `key_data`=0x00.
- **Bad parity / bad stop**:
  - 0x1C sent with parity 1: expect a 1-cycle `frame_err` pulse and `ready` staying 0.
  - Stop bit 0: same response.
- **Overflow**: send 0x01 through 0x09 with no reads. Expect count 8 and `overflow`=1. Eight reads return 0x01..0x08, with `overflow` clearing on the first pop. After the eighth read, `ready`=0.
- **Simultaneous push/pop at full**: fill with 0x01..0x08. Time the `io_rdn` rising edge to the same cycle as the push of 0x0A. Expect `overflow`=0; subsequent reads return 0x02..0x08, then 0x0A.
- **Timeout**:
  - Send the start bit plus 4 data bits, then idle for `TIMEOUT`+10 cycles. Expect a `frame_err` pulse and the FSM back in IDLE.
  - Then send 0xF0: expect `key_data`=0xF0.
- **Reset mid-frame**: assert `clrn`=0 after 6 bits of 0x5A, then release and send a full 0x5A frame. Expect all outputs at their reset values during reset, then `key_data`=0x5A with `ready`=1.
